// File: rtl/penc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | penc_pkg: shared FSM state type and constants for the priority scan  |
// | encoder.                                                             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package penc_pkg;

  typedef enum logic [0:0] {
    PENC_IDLE = 1'b0,
    PENC_SCAN = 1'b1
  } penc_state_t;

  localparam int PENC_ERR_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/penc_ffs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | penc_ffs: combinational find-first-set on a WIDTH-bit vector.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module penc_ffs
  import penc_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             single,
  output logic [WIDTH-1:0] vec_clr
);

  // Scanning from the top down lets the lowest set bit win.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

  assign any     = |vec;
  assign vec_clr = vec & (vec - WIDTH'(1));
  assign single  = any && (vec_clr == '0);

endmodule
`default_nettype wire

// File: rtl/priority_scan_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | priority_scan_encoder: emits the index of every set request bit,     |
// | lowest first, one per output handshake. Optional PENC_ERR_CNT_EN.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module priority_scan_encoder
  import penc_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             err
`ifdef PENC_ERR_CNT_EN
  ,
  output logic [PENC_ERR_CNT_W-1:0] err_cnt
`endif
);

  if ((WIDTH < 2) || (WIDTH > 256)) begin : g_width_check
    $error("priority_scan_encoder: WIDTH out of range 2..256");
  end

  penc_state_t      state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic             w_single;
  logic [WIDTH-1:0] w_vec_clr;
  logic             w_accept;
  logic             w_pop;

  penc_ffs #(
    .WIDTH (WIDTH)
  ) u_ffs (
    .vec     (pending_q),
    .idx     (w_idx),
    .any     (w_any),
    .single  (w_single),
    .vec_clr (w_vec_clr)
  );

  assign out_valid = (state_q == PENC_SCAN);
  assign busy      = (state_q == PENC_SCAN);
  assign out_idx   = w_idx;
  assign out_last  = w_single;
  assign err       = err_q;

  assign w_pop    = out_valid && out_ready;
  assign in_ready = en && ((state_q == PENC_IDLE) || (w_pop && out_last));
  assign w_accept = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    err_d     = 1'b0;
    case (state_q)
      PENC_IDLE: begin
        if (w_accept) begin
          if (din != '0) begin
            pending_d = din;
            state_d   = PENC_SCAN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PENC_SCAN: begin
        if (w_pop) begin
          if (!out_last) begin
            pending_d = w_vec_clr;
          end else if (w_accept && (din != '0)) begin
            // Reload on the final pop so back-to-back vectors have no bubble.
            pending_d = din;
          end else begin
            pending_d = '0;
            state_d   = PENC_IDLE;
            err_d     = w_accept;
          end
        end
      end
      default: begin
        state_d   = PENC_IDLE;
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= PENC_IDLE;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

`ifdef PENC_ERR_CNT_EN
  logic [PENC_ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (err_d && (err_cnt_q != {PENC_ERR_CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + PENC_ERR_CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_priority_scan_encoder.sv
`default_nettype none
// Directed self-checking bench for priority_scan_encoder (WIDTH=8 and WIDTH=5).
module tb_priority_scan_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic       busy;
  logic       err;

  logic       in_valid5;
  logic       in_ready5;
  logic [4:0] din5;
  logic       out_valid5;
  logic       out_ready5;
  logic [2:0] out_idx5;
  logic       out_last5;
  logic       busy5;
  logic       err5;

`ifdef PENC_ERR_CNT_EN
  logic [7:0] err_cnt;
  logic [7:0] err_cnt5;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  priority_scan_encoder #(.WIDTH(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err)
`ifdef PENC_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  priority_scan_encoder #(.WIDTH(5)) u_dut5 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid5),
    .in_ready  (in_ready5),
    .din       (din5),
    .out_valid (out_valid5),
    .out_ready (out_ready5),
    .out_idx   (out_idx5),
    .out_last  (out_last5),
    .busy      (busy5),
    .err       (err5)
`ifdef PENC_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt5)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [2:0] idx, input logic last);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".idx"},   32'(out_idx),   32'(idx));
    chk({tag, ".last"},  32'(out_last),  32'(last));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; din = '0; out_ready = 1'b1;
    in_valid5 = 1'b0; din5 = '0; out_ready5 = 1'b1;
    tick(); tick();
    chk_out("rst", 1'b0, 3'd0, 1'b0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.err",  32'(err),  32'd0);
    rst = 1'b0;
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    // 1: A4 -> 2,5,7
    tick();
    din = 8'hA4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    chk_out("t1.i2", 1'b1, 3'd2, 1'b0);
    chk("t1.i2.in_ready", 32'(in_ready), 32'd0);
    chk("t1.i2.busy", 32'(busy), 32'd1);
    tick();
    chk_out("t1.i5", 1'b1, 3'd5, 1'b0);
    chk("t1.i5.in_ready", 32'(in_ready), 32'd0);
    tick();
    chk_out("t1.i7", 1'b1, 3'd7, 1'b1);
    chk("t1.i7.in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("t1.end.valid", 32'(out_valid), 32'd0);
    chk("t1.end.busy", 32'(busy), 32'd0);

    // 2: zero vector
    din = 8'h00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t2.err", 32'(err), 32'd1);
    chk("t2.valid", 32'(out_valid), 32'd0);
`ifdef PENC_ERR_CNT_EN
    chk("t2.err_cnt", 32'(err_cnt), 32'd1);
`endif
    tick();
    chk("t2.err_off", 32'(err), 32'd0);
    chk("t2.valid2", 32'(out_valid), 32'd0);

    // 3: 81 with backpressure
    din = 8'h81; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_out("t3.hold", 1'b1, 3'd0, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk_out("t3.i7", 1'b1, 3'd7, 1'b1);
    tick();
    chk("t3.end.valid", 32'(out_valid), 32'd0);

    // 4: back-to-back 10 then 03
    din = 8'h10; in_valid = 1'b1;
    tick();
    din = 8'h03;
    #1;
    chk_out("t4.i4", 1'b1, 3'd4, 1'b1);
    chk("t4.i4.in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk_out("t4.i0", 1'b1, 3'd0, 1'b0);
    tick();
    chk_out("t4.i1", 1'b1, 3'd1, 1'b1);
    tick();
    chk("t4.end.valid", 32'(out_valid), 32'd0);

    // 5: reset mid-scan of FF
    din = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_out("t5.i0", 1'b1, 3'd0, 1'b0);
    tick();
    chk_out("t5.i1", 1'b1, 3'd1, 1'b0);
    rst = 1'b1;
    #1;
    chk_out("t5.rst", 1'b0, 3'd0, 1'b0);
    chk("t5.rst.busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5.in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("t5.nostale", 32'(out_valid), 32'd0);

    // 6: en=0 during scan of 06; upstream holds 01
    din = 8'h06; in_valid = 1'b1;
    tick();
    en = 1'b0; din = 8'h01;
    #1;
    chk_out("t6.i1", 1'b1, 3'd1, 1'b0);
    chk("t6.i1.in_ready", 32'(in_ready), 32'd0);
    tick();
    chk_out("t6.i2", 1'b1, 3'd2, 1'b1);
    chk("t6.i2.in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("t6.idle.valid", 32'(out_valid), 32'd0);
    chk("t6.idle.in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("t6.blocked.valid", 32'(out_valid), 32'd0);
    en = 1'b1;
    #1;
    chk("t6.en.in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk_out("t6.held", 1'b1, 3'd0, 1'b1);
    tick();
    chk("t6.end.valid", 32'(out_valid), 32'd0);

    // WIDTH=5: top bit, then all-ones
    din5 = 5'b10000; in_valid5 = 1'b1;
    tick();
    in_valid5 = 1'b0;
    chk("w5.top.valid", 32'(out_valid5), 32'd1);
    chk("w5.top.idx",   32'(out_idx5),   32'd4);
    chk("w5.top.last",  32'(out_last5),  32'd1);
    tick();
    din5 = 5'b11111; in_valid5 = 1'b1;
    tick();
    in_valid5 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("w5.ones.valid", 32'(out_valid5), 32'd1);
      chk("w5.ones.idx",   32'(out_idx5),   32'(k));
      chk("w5.ones.last",  32'(out_last5),  (k == 4) ? 32'd1 : 32'd0);
      tick();
    end
    chk("w5.ones.end", 32'(out_valid5), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
